// File: rtl/ifft_playout_buffer.sv
// ----------------------------------------------------------------------------
// ifft_playout_buffer
//
// Return path from the IFFT driver back to the AC97 codec. Addressed real
// IFFT output words are captured into one of two frame banks (ping-pong).
// Completed banks are streamed to the codec one sample per ready strobe.
// On readout each sample gets a left arithmetic gain shift with saturation.
// The buffer mutes on underflow and drops whole frames on overflow.
//
// Ports
//   clk              system clock, the only clock
//   reset            synchronous, active-high reset
//   ifft_data_real   signed IFFT real output word
//   ifft_addr        sample index of ifft_data_real within the frame
//   ifft_valid       write strobe for ifft_data_real / ifft_addr
//   ifft_done        one-cycle end-of-frame pulse (may coincide with last write)
//   gain_shift       left arithmetic shift applied on readout (0..7)
//   ready            one-cycle codec sample strobe
//   to_codec_sample  signed sample to the codec, held between strobes
//   sample_valid     one-cycle pulse, 2 clocks after an accepted ready
//   playing          high once the first frame has started playback
//   underflow        sticky: a ready found no full bank while playing
//   overflow         sticky: a frame arrived with no free bank
// ----------------------------------------------------------------------------
module ifft_playout_buffer #(
    parameter int FRAME_LEN = 512,
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ifft_data_real,
    input  logic [ADDR_W-1:0] ifft_addr,
    input  logic              ifft_valid,
    input  logic              ifft_done,
    input  logic [2:0]        gain_shift,
    input  logic              ready,
    output logic [DATA_W-1:0] to_codec_sample,
    output logic              sample_valid,
    output logic              playing,
    output logic              underflow,
    output logic              overflow
);

    localparam int WIDE_W = DATA_W + 7;

    localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((2**(DATA_W-1)) - 1);
    localparam logic signed [WIDE_W-1:0] SAT_MIN = WIDE_W'(-(2**(DATA_W-1)));

    // Both banks live in one array addressed by {bank, index}, so a single
    // write port and a single read port cover the ping-pong pair.
    logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

    logic              wbank;
    logic              rbank;
    logic [ADDR_W-1:0] rptr;
    logic [1:0]        full;
    logic              drop;

    // Read pipeline stage 1: RAM output register plus its control bits.
    logic              rd_busy;
    logic              rd_mute;
    logic [DATA_W-1:0] rd_data;

    logic              wr_en;
    logic              wr_reject;
    logic              frame_drop;
    logic              frame_commit;
    logic              rd_accept;
    logic              rd_hit;
    logic              rd_release;
    logic [1:0]        full_nxt;

    logic signed [WIDE_W-1:0] wide_in;
    logic signed [WIDE_W-1:0] wide_shifted;
    logic [DATA_W-1:0]        shaped;

    // ------------------------------------------------------------------------
    // Bank bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        wr_reject    = ifft_valid && full[wbank];
        wr_en        = ifft_valid && !full[wbank] && !drop;
        // A done against a still-full write bank is treated like a dropped
        // frame, otherwise it would re-mark the bank being played.
        frame_drop   = ifft_done && (drop || full[wbank]);
        frame_commit = ifft_done && !frame_drop;

        // A ready that lands while the previous read is still in stage 1
        // is ignored.
        rd_accept    = ready && !rd_busy;
        rd_hit       = rd_accept && full[rbank];
        rd_release   = rd_hit && (rptr == ADDR_W'(FRAME_LEN - 1));

        // Release and commit always target different banks, because a bank
        // being read is full and commit only targets a non-full bank.
        full_nxt = full;
        if (rd_release) begin
            full_nxt[rbank] = 1'b0;
        end
        if (frame_commit) begin
            full_nxt[wbank] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Storage: synchronous write, synchronous read, no reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[{wbank, ifft_addr}] <= ifft_data_real;
        end
        if (rd_hit) begin
            rd_data <= mem[{rbank, rptr}];
        end
    end

    // ------------------------------------------------------------------------
    // Gain shift and saturation (stage 2, feeds the output register)
    // ------------------------------------------------------------------------
    always_comb begin
        wide_in      = {{(WIDE_W-DATA_W){rd_data[DATA_W-1]}}, rd_data};
        wide_shifted = wide_in <<< gain_shift;
        if (wide_shifted > SAT_MAX) begin
            shaped = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (wide_shifted < SAT_MIN) begin
            shaped = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            shaped = wide_shifted[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wbank           <= 1'b0;
            rbank           <= 1'b0;
            rptr            <= '0;
            full            <= 2'b00;
            drop            <= 1'b0;
            rd_busy         <= 1'b0;
            rd_mute         <= 1'b0;
            to_codec_sample <= '0;
            sample_valid    <= 1'b0;
            playing         <= 1'b0;
            underflow       <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            full <= full_nxt;

            // Write side
            if (frame_commit) begin
                wbank <= ~wbank;
            end
            if (ifft_done) begin
                drop <= 1'b0;
            end else if (wr_reject) begin
                drop <= 1'b1;
            end
            if ((ifft_valid || ifft_done) && full[wbank]) begin
                overflow <= 1'b1;
            end

            // Read side, stage 1
            rd_busy <= rd_accept;
            rd_mute <= rd_accept && !full[rbank];
            if (rd_hit) begin
                playing <= 1'b1;
                rptr    <= rd_release ? '0 : rptr + 1'b1;
                if (rd_release) begin
                    rbank <= ~rbank;
                end
            end
            if (rd_accept && !full[rbank] && playing) begin
                underflow <= 1'b1;
            end

            // Read side, stage 2: register the shaped (or muted) sample
            sample_valid <= rd_busy;
            if (rd_busy) begin
                to_codec_sample <= rd_mute ? '0 : shaped;
            end
        end
    end

endmodule

// File: tb/tb_ifft_playout_buffer.sv
module tb_ifft_playout_buffer;

    localparam int FRAME_LEN = 512;
    localparam int ADDR_W    = 9;
    localparam int DATA_W    = 18;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] ifft_data_real = '0;
    logic [ADDR_W-1:0] ifft_addr = '0;
    logic              ifft_valid = 1'b0;
    logic              ifft_done = 1'b0;
    logic [2:0]        gain_shift = 3'd0;
    logic              ready = 1'b0;
    logic [DATA_W-1:0] to_codec_sample;
    logic              sample_valid;
    logic              playing;
    logic              underflow;
    logic              overflow;

    always #5 clk = ~clk;

    ifft_playout_buffer #(
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ifft_data_real  (ifft_data_real),
        .ifft_addr       (ifft_addr),
        .ifft_valid      (ifft_valid),
        .ifft_done       (ifft_done),
        .gain_shift      (gain_shift),
        .ready           (ready),
        .to_codec_sample (to_codec_sample),
        .sample_valid    (sample_valid),
        .playing         (playing),
        .underflow       (underflow),
        .overflow        (overflow)
    );

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] exp_q[$];   // expected output samples, in order
    logic [DATA_W-1:0] pend_q[$];  // accepted frame samples not yet played
    logic [DATA_W-1:0] frm [FRAME_LEN];
    bit model_playing;
    bit model_underflow;
    bit model_overflow;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] shaped(input logic [DATA_W-1:0] s, input int g);
        longint v;
        v = longint'($signed(s)) * (longint'(1) << g);
        if (v > 131071) v = 131071;
        else if (v < -131072) v = -131072;
        return v[DATA_W-1:0];
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (!reset && sample_valid) begin
            if (exp_q.size() == 0) check_val("spurious_sample", 1, 0);
            else check_val("sample", longint'(to_codec_sample), longint'(exp_q.pop_front()));
        end
    end

    task automatic play_one();
        logic [DATA_W-1:0] e;
        if (pend_q.size() > 0) begin
            e = shaped(pend_q.pop_front(), int'(gain_shift));
            model_playing = 1'b1;
        end else begin
            e = '0;
            if (model_playing) model_underflow = 1'b1;
        end
        exp_q.push_back(e);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        check_val("valid_r1", longint'(sample_valid), 0);
        @(negedge clk) check_val("valid_r2", longint'(sample_valid), 1);
        @(negedge clk) check_val("valid_r3", longint'(sample_valid), 0);
    endtask

    task automatic write_frame(input int n, input bit with_done, input int stride);
        bit accept;
        int a;
        accept = with_done && (n == FRAME_LEN) &&
                 (((pend_q.size() + FRAME_LEN - 1) / FRAME_LEN) < 2);
        if (with_done && !accept) model_overflow = 1'b1;
        for (int k = 0; k < n; k++) begin
            a = (k * stride) % FRAME_LEN;
            @(negedge clk);
            ifft_valid     = 1'b1;
            ifft_addr      = ADDR_W'(a);
            ifft_data_real = frm[a];
            ifft_done      = with_done && (k == n - 1);
        end
        @(negedge clk);
        ifft_valid = 1'b0;
        ifft_done  = 1'b0;
        if (accept) for (int k = 0; k < FRAME_LEN; k++) pend_q.push_back(frm[k]);
    endtask

    task automatic check_flags(input string tag);
        check_val({tag, "_playing"},   longint'(playing),   longint'(model_playing));
        check_val({tag, "_underflow"}, longint'(underflow), longint'(model_underflow));
        check_val({tag, "_overflow"},  longint'(overflow),  longint'(model_overflow));
        check_val({tag, "_drain"},     longint'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ifft_valid = 1'b0; ifft_done = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pend_q.delete();
        model_playing = 1'b0; model_underflow = 1'b0; model_overflow = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] gtab [8];
        gtab[0] = 18'h01000; gtab[1] = 18'h0F000; gtab[2] = 18'h30000; gtab[3] = 18'h04000;
        gtab[4] = 18'h3C000; gtab[5] = 18'h3FFFF; gtab[6] = 18'h03FFF; gtab[7] = 18'h00ABC;

        repeat (3) @(negedge clk);
        check_val("rst_sample",    longint'(to_codec_sample), 0);
        check_val("rst_valid",     longint'(sample_valid), 0);
        check_val("rst_playing",   longint'(playing), 0);
        check_val("rst_underflow", longint'(underflow), 0);
        check_val("rst_overflow",  longint'(overflow), 0);
        reset = 1'b0;

        // Start-up silence: zero sample, no underflow
        play_one();
        check_flags("startup");

        // Ramp frame, gain 0
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = DATA_W'(k);
        write_frame(FRAME_LEN, 1'b1, 1);
        repeat (FRAME_LEN) play_one();
        check_flags("ramp");

        // Underflow after playback ran dry
        repeat (5) play_one();
        check_flags("underflow");
        do_reset();
        check_flags("post_reset");

        // Back-to-back frames A and B
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = 18'h00100;
        write_frame(FRAME_LEN, 1'b1, 1);
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = 18'h3FF00;
        write_frame(FRAME_LEN, 1'b1, 1);
        repeat (2 * FRAME_LEN) play_one();
        check_flags("ab");

        // Gain shift 3 with clamp and boundary values
        gain_shift = 3'd3;
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = gtab[k % 8];
        write_frame(FRAME_LEN, 1'b1, 1);
        repeat (FRAME_LEN) play_one();
        check_flags("gain");
        gain_shift = 3'd0;

        // Overflow: two banks filled, third frame dropped (scattered write order)
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = DATA_W'(k) ^ 18'h2A5A5;
        write_frame(FRAME_LEN, 1'b1, 37);
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = 18'h20000 + DATA_W'(3 * k);
        write_frame(FRAME_LEN, 1'b1, 37);
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = 18'h12345;
        write_frame(FRAME_LEN, 1'b1, 1);
        check_flags("ovf_pre");
        repeat (2 * FRAME_LEN + 1) play_one();
        check_flags("ovf_play");

        // Reset mid-frame, then a fresh frame
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = 18'h0BEEF;
        write_frame(200, 1'b0, 1);
        do_reset();
        check_flags("midrst");
        for (int k = 0; k < FRAME_LEN; k++) frm[k] = 18'h15000 + DATA_W'(k);
        write_frame(FRAME_LEN, 1'b1, 1);
        repeat (FRAME_LEN + 1) play_one();
        check_flags("fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
